// File: rtl/race_sequencer.sv
// -----------------------------------------------------------------------------
// race_sequencer
// Top-level race flow controller. Steps once per video frame (frame_start)
// through IDLE -> COUNTDOWN -> RACING (<-> CRASHED) -> FINISHING -> DONE.
// Owns the player speed and the accumulated distance, and raises stop_signal
// plus a one-clock race_done pulse when the car has rolled to a stop after
// crossing the finish.
//
// Ports:
//   clk             system clock
//   resetN          synchronous reset, active-high (1 = reset)
//   frame_start     one-cycle pulse at the start of each frame
//   start_btn       debounced start key level (rising edge is the event)
//   accel_btn       throttle level
//   crash           one-cycle collision pulse
//   state           0=IDLE 1=COUNTDOWN 2=RACING 3=CRASHED 4=FINISHING 5=DONE
//   countdown_digit digit shown during COUNTDOWN (3..1), 0 otherwise
//   speed           current speed in units/frame
//   distance_drove  accumulated distance, saturating
//   stop_signal     high in FINISHING and DONE
//   race_done       one-clock pulse on entry to DONE
// -----------------------------------------------------------------------------
module race_sequencer #(
  parameter int unsigned TRACK_LENGTH     = 20000,
  parameter int unsigned FRAMES_PER_DIGIT = 60,
  parameter int unsigned ACCEL_FRAMES     = 4,
  parameter int unsigned MAX_SPEED        = 12,
  parameter int unsigned CRASH_FRAMES     = 90
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        frame_start,
  input  logic        start_btn,
  input  logic        accel_btn,
  input  logic        crash,
  output logic [2:0]  state,
  output logic [1:0]  countdown_digit,
  output logic [7:0]  speed,
  output logic [31:0] distance_drove,
  output logic        stop_signal,
  output logic        race_done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_RACING    = 3'd2,
    S_CRASHED   = 3'd3,
    S_FINISHING = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam logic [15:0] DIGIT_LAST_C = 16'(FRAMES_PER_DIGIT - 1);
  localparam logic [15:0] ACCEL_LAST_C = 16'(ACCEL_FRAMES - 1);
  localparam logic [15:0] CRASH_LAST_C = 16'(CRASH_FRAMES - 1);
  localparam logic [7:0]  MAX_SPEED_C  = 8'(MAX_SPEED);
  localparam logic [32:0] TRACK_C      = 33'(TRACK_LENGTH);

  // Distance accumulation clamps at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add_dist(input logic [31:0] d, input logic [7:0] s);
    logic [32:0] sum;
    sum = {1'b0, d} + {25'd0, s};
    if (sum[32]) begin
      sat_add_dist = 32'hFFFF_FFFF;
    end else begin
      sat_add_dist = sum[31:0];
    end
  endfunction

  // One speed step up, capped at the ceiling.
  function automatic logic [7:0] speed_up(input logic [7:0] s);
    if (s >= MAX_SPEED_C) begin
      speed_up = MAX_SPEED_C;
    end else begin
      speed_up = s + 8'd1;
    end
  endfunction

  // One speed step down, floored at zero.
  function automatic logic [7:0] speed_down(input logic [7:0] s);
    if (s == 8'd0) begin
      speed_down = 8'd0;
    end else begin
      speed_down = s - 8'd1;
    end
  endfunction

  state_t      state_r, state_nxt;
  logic [1:0]  digit_r, digit_nxt;
  logic [7:0]  speed_r, speed_nxt;
  logic [31:0] dist_r, dist_nxt;
  logic        stop_r, stop_nxt;
  logic        done_r, done_nxt;
  logic [15:0] frame_cnt_r, frame_cnt_nxt;
  logic [15:0] accel_cnt_r, accel_cnt_nxt;
  logic [15:0] crash_cnt_r, crash_cnt_nxt;
  logic        start_prev_r;
  logic        start_pend_r, start_pend_nxt;
  logic        crash_pend_r, crash_pend_nxt;

  logic        start_rise_s;
  logic        start_evt_s;
  logic        crash_evt_s;
  logic        finish_s;

  assign start_rise_s = start_btn & ~start_prev_r;
  // A rise or crash in the same cycle as frame_start counts for that frame.
  assign start_evt_s  = start_pend_r | start_rise_s;
  assign crash_evt_s  = crash_pend_r | crash;
  // 33-bit compare so a near-full distance cannot wrap past the track length.
  assign finish_s     = (({1'b0, dist_r} + {25'd0, speed_r}) > TRACK_C);

  // Next-state and datapath updates; everything moves only on frame_start.
  always_comb begin
    state_nxt      = state_r;
    digit_nxt      = digit_r;
    speed_nxt      = speed_r;
    dist_nxt       = dist_r;
    stop_nxt       = stop_r;
    done_nxt       = 1'b0;
    frame_cnt_nxt  = frame_cnt_r;
    accel_cnt_nxt  = accel_cnt_r;
    crash_cnt_nxt  = crash_cnt_r;
    start_pend_nxt = start_pend_r;
    crash_pend_nxt = crash_pend_r;

    if (frame_start) begin
      // Sticky events are consumed (or discarded) at every frame boundary.
      start_pend_nxt = 1'b0;
      crash_pend_nxt = 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start_evt_s) begin
            state_nxt     = S_COUNTDOWN;
            digit_nxt     = 2'd3;
            frame_cnt_nxt = 16'd0;
            accel_cnt_nxt = 16'd0;
            dist_nxt      = 32'd0;
            speed_nxt     = 8'd0;
            stop_nxt      = 1'b0;
          end else begin
            state_nxt = S_IDLE;
          end
        end
        S_COUNTDOWN: begin
          if (frame_cnt_r == DIGIT_LAST_C) begin
            frame_cnt_nxt = 16'd0;
            if (digit_r == 2'd1) begin
              state_nxt = S_RACING;
              digit_nxt = 2'd0;
            end else begin
              digit_nxt = digit_r - 2'd1;
            end
          end else begin
            frame_cnt_nxt = frame_cnt_r + 16'd1;
          end
        end
        S_RACING: begin
          if (finish_s) begin
            // Finish outranks a pending crash; the crash flag is already cleared.
            state_nxt = S_FINISHING;
            stop_nxt  = 1'b1;
            dist_nxt  = sat_add_dist(dist_r, speed_r);
          end else if (crash_evt_s) begin
            state_nxt     = S_CRASHED;
            speed_nxt     = 8'd0;
            crash_cnt_nxt = 16'd0;
          end else begin
            if (accel_btn) begin
              if (accel_cnt_r == ACCEL_LAST_C) begin
                accel_cnt_nxt = 16'd0;
                speed_nxt     = speed_up(speed_r);
              end else begin
                accel_cnt_nxt = accel_cnt_r + 16'd1;
              end
            end else begin
              accel_cnt_nxt = 16'd0;
              speed_nxt     = speed_down(speed_r);
            end
            // Distance advances by the speed held during this frame.
            dist_nxt = sat_add_dist(dist_r, speed_r);
          end
        end
        S_CRASHED: begin
          if (crash_cnt_r == CRASH_LAST_C) begin
            state_nxt     = S_RACING;
            accel_cnt_nxt = 16'd0;
            crash_cnt_nxt = 16'd0;
          end else begin
            crash_cnt_nxt = crash_cnt_r + 16'd1;
          end
        end
        S_FINISHING: begin
          if (speed_r == 8'd0) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end else begin
            dist_nxt  = sat_add_dist(dist_r, speed_r);
            speed_nxt = speed_down(speed_r);
          end
        end
        S_DONE: begin
          if (start_evt_s) begin
            state_nxt = S_IDLE;
            dist_nxt  = 32'd0;
            stop_nxt  = 1'b0;
          end else begin
            state_nxt = S_DONE;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          digit_nxt = 2'd0;
          speed_nxt = 8'd0;
          dist_nxt  = 32'd0;
          stop_nxt  = 1'b0;
        end
      endcase
    end else begin
      start_pend_nxt = start_pend_r | start_rise_s;
      // Crashes only matter while racing; anywhere else they are dropped.
      crash_pend_nxt = crash_pend_r | (crash & (state_r == S_RACING));
    end
  end

  // State, datapath and edge-detect registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (resetN) begin
      state_r      <= S_IDLE;
      digit_r      <= 2'd0;
      speed_r      <= 8'd0;
      dist_r       <= 32'd0;
      stop_r       <= 1'b0;
      done_r       <= 1'b0;
      frame_cnt_r  <= 16'd0;
      accel_cnt_r  <= 16'd0;
      crash_cnt_r  <= 16'd0;
      start_prev_r <= 1'b0;
      start_pend_r <= 1'b0;
      crash_pend_r <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      digit_r      <= digit_nxt;
      speed_r      <= speed_nxt;
      dist_r       <= dist_nxt;
      stop_r       <= stop_nxt;
      done_r       <= done_nxt;
      frame_cnt_r  <= frame_cnt_nxt;
      accel_cnt_r  <= accel_cnt_nxt;
      crash_cnt_r  <= crash_cnt_nxt;
      start_prev_r <= start_btn;
      start_pend_r <= start_pend_nxt;
      crash_pend_r <= crash_pend_nxt;
    end
  end

  assign state           = state_r;
  assign countdown_digit = digit_r;
  assign speed           = speed_r;
  assign distance_drove  = dist_r;
  assign stop_signal     = stop_r;
  assign race_done       = done_r;

endmodule

// File: tb/tb_race_sequencer.sv
// -----------------------------------------------------------------------------
// tb_race_sequencer
// Self-checking bench for race_sequencer with small parameters. A behavioural
// model (remaining-frame countdowns, held-frame counting, integer distance)
// is compared with the DUT on every falling edge; directed scenarios add
// hand-computed literal expectations, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_race_sequencer;

  localparam int TL  = 20;
  localparam int FPD = 2;
  localparam int AF  = 2;
  localparam int MS  = 4;
  localparam int CF  = 3;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        frame_start = 1'b0;
  logic        start_btn = 1'b0;
  logic        accel_btn = 1'b0;
  logic        crash = 1'b0;
  logic [2:0]  state;
  logic [1:0]  countdown_digit;
  logic [7:0]  speed;
  logic [31:0] distance_drove;
  logic        stop_signal;
  logic        race_done;

  race_sequencer #(
    .TRACK_LENGTH(TL), .FRAMES_PER_DIGIT(FPD), .ACCEL_FRAMES(AF),
    .MAX_SPEED(MS), .CRASH_FRAMES(CF)
  ) dut (
    .clk(clk), .resetN(resetN), .frame_start(frame_start),
    .start_btn(start_btn), .accel_btn(accel_btn), .crash(crash),
    .state(state), .countdown_digit(countdown_digit), .speed(speed),
    .distance_drove(distance_drove), .stop_signal(stop_signal),
    .race_done(race_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: 0 idle,1 countdown,2 racing,3 crashed,4 finishing,5 done
  int     m_state = 0;
  int     m_speed = 0;
  longint m_dist = 0;
  int     m_cd_left = 0;
  int     m_crash_left = 0;
  int     m_held = 0;
  bit     m_spend = 1'b0;
  bit     m_cpend = 1'b0;
  bit     m_prev = 1'b0;
  bit     m_done = 1'b0;

  function automatic int m_digit();
    if (m_state == 1) return (m_cd_left + FPD - 1) / FPD;
    return 0;
  endfunction

  function automatic longint sat32(input longint v);
    if (v > 64'hFFFF_FFFF) return 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs present at this edge.
  task automatic model_step();
    bit s_evt, c_evt, rise;
    int old;
    rise = start_btn && !m_prev;
    m_prev = start_btn;
    if (resetN) begin
      m_state = 0; m_speed = 0; m_dist = 0; m_cd_left = 0; m_crash_left = 0;
      m_held = 0; m_spend = 0; m_cpend = 0; m_prev = 0; m_done = 0;
    end else if (!frame_start) begin
      m_done = 0;
      if (rise) m_spend = 1;
      if (crash && m_state == 2) m_cpend = 1;
    end else begin
      m_done = 0;
      s_evt = m_spend || rise;
      c_evt = m_cpend || crash;
      m_spend = 0;
      m_cpend = 0;
      case (m_state)
        0: if (s_evt) begin
             m_state = 1; m_cd_left = 3 * FPD; m_dist = 0; m_speed = 0; m_held = 0;
           end
        1: begin
             m_cd_left--;
             if (m_cd_left == 0) m_state = 2;
           end
        2: begin
             if (m_dist + m_speed > TL) begin
               m_dist = sat32(m_dist + m_speed);
               m_state = 4;
             end else if (c_evt) begin
               m_state = 3; m_speed = 0; m_crash_left = CF;
             end else begin
               old = m_speed;
               if (accel_btn) begin
                 m_held++;
                 if (m_held % AF == 0 && m_speed < MS) m_speed++;
               end else begin
                 m_held = 0;
                 if (m_speed > 0) m_speed--;
               end
               m_dist = sat32(m_dist + old);
             end
           end
        3: begin
             m_crash_left--;
             if (m_crash_left == 0) begin m_state = 2; m_held = 0; end
           end
        4: begin
             if (m_speed == 0) begin m_state = 5; m_done = 1; end
             else begin m_dist = sat32(m_dist + m_speed); m_speed--; end
           end
        5: if (s_evt) begin m_state = 0; m_dist = 0; end
        default: m_state = 0;
      endcase
    end
  endtask

  // Continuous comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", state, m_state);
      chk("digit", countdown_digit, m_digit());
      chk("speed", speed, m_speed);
      chk("distance", distance_drove, m_dist);
      chk("stop", stop_signal, (m_state == 4 || m_state == 5));
      chk("race_done", race_done, m_done);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pulse_start();
    start_btn = 1'b1; tick(); start_btn = 1'b0; tick();
  endtask

  task automatic pulse_crash();
    crash = 1'b1; tick(); crash = 1'b0; tick();
  endtask

  int dig_exp[6]  = '{3, 3, 2, 2, 1, 1};
  int spd_exp[10] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 4};
  int dst_exp[10] = '{0, 0, 1, 2, 4, 6, 9, 12, 16, 20};
  int fsp_exp[4]  = '{3, 2, 1, 0};
  int fds_exp[4]  = '{28, 31, 33, 34};

  initial begin
    // Reset
    resetN = 1'b1; tick(); tick();
    resetN = 1'b0; chk_en = 1'b1;
    chk("rst_state", state, 0);
    chk("rst_speed", speed, 0);
    chk("rst_dist", distance_drove, 0);
    chk("rst_stop", stop_signal, 0);

    // Countdown 3,3,2,2,1,1 then RACING
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      frame(); chk("cd_digit", countdown_digit, dig_exp[i]); chk("cd_state", state, 1); tick();
    end
    frame(); chk("race_state", state, 2); chk("race_digit", countdown_digit, 0);
    chk("race_speed", speed, 0); tick();

    // Acceleration with saturation at MAX_SPEED
    accel_btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      frame(); chk("acc_speed", speed, spd_exp[i]); chk("acc_dist", distance_drove, dst_exp[i]); tick();
    end

    // Finish and crash in the same frame: finish wins
    pulse_crash();
    frame(); chk("fin_state", state, 4); chk("fin_stop", stop_signal, 1);
    chk("fin_dist", distance_drove, 24); chk("fin_speed", speed, 4);
    accel_btn = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin
      frame(); chk("roll_speed", speed, fsp_exp[i]); chk("roll_dist", distance_drove, fds_exp[i]); tick();
    end
    frame(); chk("done_state", state, 5); chk("done_pulse", race_done, 1);
    tick(); chk("done_pulse_end", race_done, 0);

    // Restart from DONE
    pulse_start();
    frame(); chk("idle_state", state, 0); chk("idle_dist", distance_drove, 0);
    chk("idle_stop", stop_signal, 0); tick();

    // Second race: crash at speed 3
    pulse_start();
    for (int i = 0; i < 7; i++) begin frame(); tick(); end
    accel_btn = 1'b1;
    for (int i = 0; i < 6; i++) begin frame(); tick(); end
    chk("pre_crash_speed", speed, 3); chk("pre_crash_dist", distance_drove, 6);
    accel_btn = 1'b0;
    pulse_crash();
    frame(); chk("crash_state", state, 3); chk("crash_speed", speed, 0);
    chk("crash_dist", distance_drove, 6); tick();
    for (int i = 0; i < 2; i++) begin
      frame(); chk("frozen_state", state, 3); chk("frozen_dist", distance_drove, 6); tick();
    end
    frame(); chk("recover_state", state, 2); chk("recover_speed", speed, 0);
    chk("recover_dist", distance_drove, 6); tick();

    // Start press mid-race is discarded
    pulse_start();
    frame(); chk("ignore_start", state, 2); tick();

    // Mid-race reset
    accel_btn = 1'b1;
    for (int i = 0; i < 4; i++) begin frame(); tick(); end
    accel_btn = 1'b0;
    resetN = 1'b1; tick(); resetN = 1'b0;
    chk("mr_state", state, 0); chk("mr_speed", speed, 0); chk("mr_dist", distance_drove, 0);
    chk("mr_stop", stop_signal, 0); chk("mr_digit", countdown_digit, 0);
    for (int i = 0; i < 5; i++) begin frame(); chk("no_spurious", state, 0); tick(); end

    // Randomized run checked by the model
    for (int i = 0; i < 4000; i++) begin
      resetN      = ($urandom_range(0, 599) == 0);
      frame_start = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 5) == 0) accel_btn = ~accel_btn;
      crash = ($urandom_range(0, 24) == 0);
      tick();
    end

    resetN = 1'b0; frame_start = 1'b0; crash = 1'b0; start_btn = 1'b0; accel_btn = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
